// File: rtl/pipelined_arith_unit.sv
// Multi-lane integer unit: single-cycle ALU ops plus a MUL_LAT-deep multiply pipeline per lane.
// A completing MUL owns the lane's output register, so in_ready drops the cycle before it lands.
module pipelined_arith_unit #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                in_valid,
  input  logic [NUM_LANES-1:0][2:0]           in_op,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]    in_a,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]    in_b,
  input  logic [NUM_LANES-1:0][TAG_W-1:0]     in_tag,
  output logic [NUM_LANES-1:0]                in_ready,
  output logic [NUM_LANES-1:0]                out_valid,
  output logic [NUM_LANES-1:0][DATA_W-1:0]    out_data,
  output logic [NUM_LANES-1:0][TAG_W-1:0]     out_tag,
  input  logic                                flush_in
);

  localparam int unsigned LAST_STG = MUL_LAT - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } stage_t;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // Stage k holds a MUL k edges after acceptance; the output register is the final step.
    stage_t            r_stg [1:LAST_STG];
    stage_t            r_out;
    stage_t            w_out_nxt;
    stage_t            w_stg1_nxt;
    logic              w_is_mul;
    logic              w_take_mul;
    logic              w_take_alu;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_prod;

    assign in_ready[l]  = ~r_stg[LAST_STG].vld;
    assign w_is_mul     = (in_op[l] == OP_MUL);
    assign w_take_mul   = in_valid[l] & w_is_mul & ~flush_in;
    assign w_take_alu   = in_valid[l] & ~w_is_mul & in_ready[l] & ~flush_in;
    assign w_prod       = in_a[l] * in_b[l];

    // Reserved opcodes fall into the default arm and return zero.
    always_comb begin
      w_alu = '0;
      case (in_op[l])
        OP_ADD:  w_alu = in_a[l] + in_b[l];
        OP_SUB:  w_alu = in_a[l] - in_b[l];
        OP_AND:  w_alu = in_a[l] & in_b[l];
        OP_OR:   w_alu = in_a[l] | in_b[l];
        OP_XOR:  w_alu = in_a[l] ^ in_b[l];
        default: w_alu = '0;
      endcase
    end

    always_comb begin
      w_stg1_nxt = '0;
      if (w_take_mul) begin
        w_stg1_nxt.vld  = 1'b1;
        w_stg1_nxt.tag  = in_tag[l];
        w_stg1_nxt.data = w_prod;
      end
    end

    always_comb begin
      w_out_nxt = '0;
      if (flush_in) begin
        w_out_nxt = '0;
      end else if (r_stg[LAST_STG].vld) begin
        w_out_nxt = r_stg[LAST_STG];
      end else if (w_take_alu) begin
        w_out_nxt.vld  = 1'b1;
        w_out_nxt.tag  = in_tag[l];
        w_out_nxt.data = w_alu;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int k = 1; k <= int'(LAST_STG); k++) begin
          r_stg[k] <= '0;
        end
        r_out <= '0;
      end else begin
        r_stg[1] <= flush_in ? '0 : w_stg1_nxt;
        for (int k = 2; k <= int'(LAST_STG); k++) begin
          r_stg[k] <= flush_in ? '0 : r_stg[k-1];
        end
        r_out <= w_out_nxt;
      end
    end

    assign out_valid[l] = r_out.vld;
    assign out_data[l]  = r_out.data;
    assign out_tag[l]   = r_out.tag;
  end

endmodule

// File: tb/tb_pipelined_arith_unit.sv
// Directed bench for pipelined_arith_unit (2 lanes, 32-bit data, MUL_LAT=3).
module tb_pipelined_arith_unit;

  logic              clock;
  logic              reset;
  logic [1:0]        in_valid;
  logic [1:0][2:0]   in_op;
  logic [1:0][31:0]  in_a;
  logic [1:0][31:0]  in_b;
  logic [1:0][5:0]   in_tag;
  logic [1:0]        in_ready;
  logic [1:0]        out_valid;
  logic [1:0][31:0]  out_data;
  logic [1:0][5:0]   out_tag;
  logic              flush_in;

  int total = 0;
  int bad   = 0;

  logic [31:0] ma [4];
  logic [31:0] mb [4];
  logic [31:0] mp [4];
  logic [5:0]  mt [4];

  pipelined_arith_unit #(
    .NUM_LANES(2), .DATA_W(32), .TAG_W(6), .MUL_LAT(3)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .flush_in(flush_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_lane(input string name, input int l, input logic v,
                          input logic [31:0] d, input logic [5:0] t);
    chk({name, ".valid"}, 64'(out_valid[l]), 64'(v));
    chk({name, ".data"},  64'(out_data[l]),  64'(d));
    chk({name, ".tag"},   64'(out_tag[l]),   64'(t));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    in_op    = '0;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
  endtask

  task automatic issue(input int l, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] t);
    in_valid[l] = 1'b1;
    in_op[l]    = op;
    in_a[l]     = a;
    in_b[l]     = b;
    in_tag[l]   = t;
  endtask

  initial begin
    idle();
    flush_in = 1'b0;
    reset    = 1'b1;
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd3);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_lane("post_rst_l0", 0, 1'b0, 32'h0, 6'd0);
    chk_lane("post_rst_l1", 1, 1'b0, 32'h0, 6'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd3);

    // ADD wraps modulo 2^32
    issue(0, 3'd0, 32'hFFFF_FFFF, 32'h2, 6'd5);
    tick();
    idle();
    chk_lane("add_wrap", 0, 1'b1, 32'h1, 6'd5);
    chk("add_l1_quiet", 64'(out_valid[1]), 64'd0);
    tick();
    chk_lane("add_drop", 0, 1'b0, 32'h0, 6'd0);

    // Single MUL on lane 1: result after exactly three edges
    issue(1, 3'd5, 32'h0001_0000, 32'h0001_0003, 6'd9);
    tick();
    idle();
    chk("mul_e1_valid", 64'(out_valid[1]), 64'd0);
    chk("mul_e1_ready", 64'(in_ready), 64'd3);
    tick();
    chk("mul_e2_valid", 64'(out_valid[1]), 64'd0);
    chk("mul_e2_ready", 64'(in_ready), 64'd1);
    tick();
    chk_lane("mul_e3", 1, 1'b1, 32'h0003_0000, 6'd9);
    chk("mul_e3_ready", 64'(in_ready), 64'd3);
    tick();
    chk("mul_e4_valid", 64'(out_valid[1]), 64'd0);

    // Both lanes in parallel, remaining ALU ops and a reserved opcode
    issue(0, 3'd1, 32'd10, 32'd3, 6'd1);
    issue(1, 3'd2, 32'h0000_F0F0, 32'h0000_FF00, 6'd2);
    tick();
    chk_lane("sub_l0", 0, 1'b1, 32'd7, 6'd1);
    chk_lane("and_l1", 1, 1'b1, 32'h0000_F000, 6'd2);
    idle();
    issue(0, 3'd3, 32'h0000_00A0, 32'h0000_000B, 6'd3);
    issue(1, 3'd6, 32'd5, 32'd5, 6'd4);
    tick();
    chk_lane("or_l0", 0, 1'b1, 32'h0000_00AB, 6'd3);
    chk_lane("resv_l1", 1, 1'b1, 32'h0, 6'd4);
    idle();
    tick();
    chk("par_quiet", 64'(out_valid), 64'd0);

    // MUL then an XOR held while in_ready is low; both results exactly once
    issue(0, 3'd5, 32'd7, 32'd6, 6'd10);
    tick();
    idle();
    chk("hold_e1_ready", 64'(in_ready[0]), 64'd1);
    tick();
    chk("hold_e2_ready", 64'(in_ready[0]), 64'd0);
    issue(0, 3'd4, 32'h0000_FF00, 32'h0000_0FF0, 6'd11);
    tick();
    chk_lane("hold_mul", 0, 1'b1, 32'd42, 6'd10);
    chk("hold_e3_ready", 64'(in_ready[0]), 64'd1);
    tick();
    idle();
    chk_lane("hold_xor", 0, 1'b1, 32'h0000_F0F0, 6'd11);
    tick();
    chk("hold_once", 64'(out_valid[0]), 64'd0);

    // Four back-to-back MULs on lane 1
    ma[0] = 32'd2;          mb[0] = 32'd3;          mp[0] = 32'd6;          mt[0] = 6'd20;
    ma[1] = 32'd4;          mb[1] = 32'd5;          mp[1] = 32'd20;         mt[1] = 6'd21;
    ma[2] = 32'hFFFF_FFFF;  mb[2] = 32'hFFFF_FFFF;  mp[2] = 32'h1;          mt[2] = 6'd22;
    ma[3] = 32'h1234_5678;  mb[3] = 32'h10;         mp[3] = 32'h2345_6780;  mt[3] = 6'd23;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 4) issue(1, 3'd5, ma[i], mb[i], mt[i]);
      tick();
      if (i >= 2 && i < 6) chk_lane($sformatf("b2b_%0d", i - 2), 1, 1'b1, mp[i-2], mt[i-2]);
      else                 chk_lane($sformatf("b2b_idle_%0d", i), 1, 1'b0, 32'h0, 6'd0);
    end
    idle();

    // Flush one cycle after a MUL, with an ADD presented in the flush cycle
    issue(0, 3'd5, 32'd3, 32'd3, 6'd12);
    tick();
    idle();
    flush_in = 1'b1;
    issue(0, 3'd0, 32'd1, 32'd1, 6'd13);
    tick();
    flush_in = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("flush_valid_%0d", i), 64'(out_valid), 64'd0);
      chk($sformatf("flush_ready_%0d", i), 64'(in_ready), 64'd3);
      tick();
    end

    // Reset mid-MUL, then a SUB: only the SUB result may appear
    issue(1, 3'd5, 32'd5, 32'd5, 6'd14);
    tick();
    idle();
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd3);
    reset = 1'b0;
    issue(1, 3'd1, 32'd3, 32'd5, 6'd15);
    tick();
    idle();
    chk_lane("midrst_sub", 1, 1'b1, 32'hFFFF_FFFE, 6'd15);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_stale_%0d", i), 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
